// File: rtl/gs_ddram_bridge.sv
// Byte-wide GS memory port to 64-bit DDR3 Avalon master, with a single-line
// write-through read cache so sequential GS fetches avoid a DDR round trip.
module gs_ddram_bridge #(
    parameter logic [28:0] BASE_ADDR = 29'h0600_0000
) (
    input  logic        DDRAM_CLK,
    input  logic        RESET_N,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE,
    input  logic [20:0] addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        rd,
    input  logic        we,
    output logic        ready
);

    typedef enum logic [2:0] {S_IDLE, S_HIT, S_RD, S_RDW, S_WR} state_t;

    state_t      state, state_nx;
    logic        req, req_d, accept, tag_hit, fill;
    logic        we_q;
    logic [20:0] addr_q;
    logic [7:0]  din_q;
    logic [63:0] cache_line;
    logic [17:0] cache_tag;
    logic        cache_valid;

    assign req     = rd | we;
    assign tag_hit = cache_valid && (addr[20:3] == cache_tag);
    // A level request is taken once; it re-arms on a gap, a new address or a new op type.
    assign accept  = (state == S_IDLE) && req && (!req_d || (addr != addr_q) || (we != we_q));

    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = BASE_ADDR + {11'd0, addr_q[20:3]};
    assign DDRAM_DIN      = {8{din_q}};
    assign DDRAM_BE       = 8'b1 << addr_q[2:0];

    always_ff @(posedge DDRAM_CLK) begin
        if (!RESET_N) begin
            state <= S_IDLE;
            ready <= 1'b1;
        end else begin
            state <= state_nx;
            ready <= (state_nx == S_IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        fill     = 1'b0;
        DDRAM_RD = 1'b0;
        DDRAM_WE = 1'b0;
        case (state)
            S_IDLE: if (accept) state_nx = we ? S_WR : (tag_hit ? S_HIT : S_RD);
            S_HIT:  state_nx = S_IDLE;
            S_RD: begin
                DDRAM_RD = 1'b1;
                if (!DDRAM_BUSY) state_nx = S_RDW;
            end
            S_RDW: if (DDRAM_DOUT_READY) begin
                fill     = 1'b1;
                state_nx = S_IDLE;
            end
            S_WR: begin
                DDRAM_WE = 1'b1;
                if (!DDRAM_BUSY) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge DDRAM_CLK) begin
        if (!RESET_N) begin
            req_d       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            cache_line  <= '0;
            cache_tag   <= '0;
            cache_valid <= 1'b0;
            dout        <= 8'hFF;
        end else begin
            req_d <= req;
            if (accept) begin
                we_q   <= we;
                addr_q <= addr;
                din_q  <= din;
                if (we) begin
                    // Write-through only; a miss does not allocate the line.
                    if (tag_hit) cache_line[{addr[2:0], 3'b000} +: 8] <= din;
                end else if (tag_hit) begin
                    dout <= cache_line[{addr[2:0], 3'b000} +: 8];
                end
            end
            if (fill) begin
                cache_line  <= DDRAM_DOUT;
                cache_tag   <= addr_q[20:3];
                cache_valid <= 1'b1;
                dout        <= DDRAM_DOUT[{addr_q[2:0], 3'b000} +: 8];
            end
        end
    end

endmodule

// File: tb/tb_gs_ddram_bridge.sv
// Bench for gs_ddram_bridge: DDR slave model, cache/memory reference model and
// per-cycle bus checker, driven by directed GS accesses.
module tb_gs_ddram_bridge;

    localparam logic [28:0] BASE = 29'h0600_0000;
    localparam int K_HIT = 0, K_MISS = 1, K_WR = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ddr_busy = 1'b0;
    logic [7:0]  ddr_burstcnt;
    logic [28:0] ddr_addr;
    logic [63:0] ddr_dout = '0;
    logic        ddr_ready = 1'b0;
    logic        ddr_rd, ddr_we;
    logic [63:0] ddr_din;
    logic [7:0]  ddr_be;
    logic [20:0] addr = '0;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    logic        rd = 1'b0, we = 1'b0;
    logic        ready;

    gs_ddram_bridge #(.BASE_ADDR(BASE)) dut (
        .DDRAM_CLK(clk), .RESET_N(rst_n), .DDRAM_BUSY(ddr_busy),
        .DDRAM_BURSTCNT(ddr_burstcnt), .DDRAM_ADDR(ddr_addr), .DDRAM_DOUT(ddr_dout),
        .DDRAM_DOUT_READY(ddr_ready), .DDRAM_RD(ddr_rd), .DDRAM_DIN(ddr_din),
        .DDRAM_BE(ddr_be), .DDRAM_WE(ddr_we), .addr(addr), .din(din), .dout(dout),
        .rd(rd), .we(we), .ready(ready)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0, tot_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    endtask

    // Reference: DDR contents plus the single cached line
    logic [63:0] mem [logic [28:0]];
    bit          m_valid = 0;
    logic [17:0] m_tag = '0;
    logic [63:0] m_line = '0;

    function automatic logic [63:0] mem_get(input logic [28:0] a);
        if (mem.exists(a)) return mem[a];
        return {35'd0, a} ^ 64'hC0FF_EE00_0000_0000;
    endfunction

    int          exp_kind = K_HIT;
    logic [28:0] exp_addr = '0;
    logic [7:0]  exp_be = '0;
    logic [63:0] exp_din = '0;
    int          rd_iss = 0, we_iss = 0, we_cyc = 0;
    logic [28:0] obs_addr = '0;
    logic [7:0]  obs_be = '0;
    logic [63:0] obs_din = '0;
    int          cfg_busy = 0, cfg_lat = 5;

    logic        p_rd = 0, p_we = 0;
    logic [28:0] p_addr = '0;
    bit          in_req = 0;
    int          left = 0, pend = 0;
    logic [63:0] pend_word = '0;

    // Bus checker first (sees BUSY as it was at the last edge), then the DDR slave.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ddr_rd || ddr_we) begin
                chk("ddr_op", {ddr_rd, ddr_we}, (exp_kind == K_WR) ? 2'b01 : 2'b10);
                chk("ddr_addr", ddr_addr, exp_addr);
                chk("burstcnt", ddr_burstcnt, 8'd1);
                if (ddr_we) begin
                    chk("ddr_be", ddr_be, exp_be);
                    chk("ddr_din", ddr_din, exp_din);
                    we_cyc++;
                    obs_be  = ddr_be;
                    obs_din = ddr_din;
                end
                obs_addr = ddr_addr;
            end
            if (ddr_busy && (p_rd || p_we))
                chk("hold_busy", {ddr_rd, ddr_we, ddr_addr}, {p_rd, p_we, p_addr});
            if (ddr_rd && !p_rd) rd_iss++;
            if (ddr_we && !p_we) we_iss++;
        end
        p_rd   = ddr_rd;
        p_we   = ddr_we;
        p_addr = ddr_addr;

        ddr_ready = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                ddr_ready = 1'b1;
                ddr_dout  = pend_word;
            end
        end
        if (ddr_rd || ddr_we) begin
            if (!in_req) begin
                in_req = 1;
                left   = cfg_busy;
            end else if (left > 0) left--;
            ddr_busy = (left > 0);
            if (ddr_rd && !ddr_busy) begin
                pend      = cfg_lat;
                pend_word = mem_get(ddr_addr);
            end
        end else begin
            in_req   = 0;
            ddr_busy = 1'b0;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic do_op(input bit w, input logic [20:0] a, input logic [7:0] d,
                         input int hold, input bit drop, output int low);
        logic [63:0] word;
        logic [7:0]  e;
        int          idx;
        idx      = int'(a[2:0]);
        e        = 8'h00;
        exp_addr = BASE + {11'd0, a[20:3]};
        exp_be   = 8'b1 << a[2:0];
        exp_din  = {8{d}};
        if (w) begin
            exp_kind = K_WR;
            word = mem_get(exp_addr);
            word[idx*8 +: 8] = d;
            mem[exp_addr] = word;
            if (m_valid && m_tag == a[20:3]) m_line[idx*8 +: 8] = d;
        end else if (m_valid && m_tag == a[20:3]) begin
            exp_kind = K_HIT;
            e = m_line[idx*8 +: 8];
        end else begin
            exp_kind = K_MISS;
            m_line  = mem_get(exp_addr);
            m_tag   = a[20:3];
            m_valid = 1;
            e = m_line[idx*8 +: 8];
        end
        rd_iss = 0; we_iss = 0; we_cyc = 0;
        addr = a; din = d; rd = !w; we = w;
        low = 0;
        tick;
        while (!ready && low < 100) begin
            low++;
            tick;
        end
        chk("op_timeout", low < 100, 1);
        if (!w) chk("dout", dout, e);
        repeat (hold) tick;
        chk("rd_issued", rd_iss, exp_kind == K_MISS);
        chk("we_issued", we_iss, w);
        if (drop) begin
            rd = 0; we = 0;
            tick;
        end
    endtask

    initial begin
        int low;
        mem[BASE + 29'd2] = 64'h8877_6655_4433_2211;

        repeat (2) tick;
        chk("rst_ready", ready, 1);
        chk("rst_rd", ddr_rd, 0);
        chk("rst_we", ddr_we, 0);
        chk("rst_dout", dout, 8'hFF);
        rst_n = 1;
        tick;

        cfg_busy = 3;
        do_op(1, 21'h000005, 8'h5A, 0, 1, low);
        chk("wr_addr", obs_addr, 29'h0600_0000);
        chk("wr_be", obs_be, 8'h20);
        chk("wr_din", obs_din, 64'h5A5A_5A5A_5A5A_5A5A);
        chk("wr_we_cycles", we_cyc, 4);
        chk("wr_ready_low", low, 4);

        cfg_busy = 0; cfg_lat = 5;
        do_op(0, 21'h000010, 8'h00, 0, 1, low);
        chk("miss_addr", obs_addr, 29'h0600_0002);
        chk("miss_dout", dout, 8'h11);
        chk("miss_ready_low", low, 6);

        do_op(0, 21'h000013, 8'h00, 2, 0, low);
        chk("hit_dout", dout, 8'h44);
        chk("hit_ready_low", low, 1);
        do_op(0, 21'h000011, 8'h00, 0, 1, low);
        chk("hit_addrchg_dout", dout, 8'h22);
        chk("hit_addrchg_low", low, 1);

        cfg_busy = 1;
        do_op(1, 21'h000013, 8'hAB, 0, 1, low);
        cfg_busy = 0;
        do_op(0, 21'h000013, 8'h00, 0, 1, low);
        chk("wt_dout", dout, 8'hAB);
        chk("wt_ready_low", low, 1);

        do_op(1, 21'h000100, 8'h55, 0, 1, low);
        do_op(0, 21'h000010, 8'h00, 0, 1, low);
        chk("noalloc_dout", dout, 8'h11);
        chk("noalloc_rd", rd_iss, 0);

        do_op(1, 21'h1FFFFF, 8'h3C, 0, 1, low);
        chk("top_addr", obs_addr, 29'h0603_FFFF);
        chk("top_be", obs_be, 8'h80);

        // Reset while a read miss is waiting on data
        cfg_lat  = 10;
        exp_kind = K_MISS;
        exp_addr = BASE + 29'h40;
        addr = 21'h000200; rd = 1;
        repeat (3) tick;
        rst_n = 0; rd = 0;
        repeat (2) tick;
        rst_n = 1;
        m_valid = 0;
        chk("rst_mid_ready", ready, 1);
        chk("rst_mid_rd", ddr_rd, 0);
        repeat (12) begin
            tick;
            chk("late_ready_idle", ready, 1);
            chk("late_ready_dout", dout, 8'hFF);
        end

        cfg_lat = 5;
        do_op(0, 21'h000013, 8'h00, 5, 1, low);
        chk("post_rst_dout", dout, 8'hAB);
        chk("post_rst_one_rd", rd_iss, 1);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
